// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only-write data memory: sub-word stores become
// read-modify-write, sub-word loads are lane-extracted and sign/zero extended.
module lsu_rmw #(
  parameter int BITS_ADDR = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Req,
  input  logic                 ReqWE,
  input  logic [1:0]           Size,
  input  logic                 Unsigned,
  input  logic [BITS_ADDR-1:0] Addr,
  input  logic [31:0]          StoreData,
  output logic                 Ready,
  output logic                 Done,
  output logic                 Misaligned,
  output logic [31:0]          LoadData,
  output logic [BITS_ADDR-3:0] MemAddr,
  output logic [31:0]          MemWData,
  output logic                 MemWE,
  input  logic [31:0]          MemRData
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  state_t               state_q, state_d;
  logic [BITS_ADDR-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 we_q, we_d;
  logic                 uns_q, uns_d;
  logic [15:0]          sdata_q, sdata_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          ldata_q, ldata_d;

  logic                 misal;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [31:0]          merged;
  logic [31:0]          ext;

  // Lane selection is little-endian within the addressed word.
  always_comb begin
    rd_byte = MemRData[{addr_q[1:0], 3'b000} +: 8];
    rd_half = MemRData[{addr_q[1], 4'b0000} +: 16];
    merged  = MemRData;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
    case (size_q)
      2'b00:   ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ext = MemRData;
    endcase
  end

  always_comb begin
    misal = (Size == 2'b11) || (Size == 2'b01 && Addr[0]) ||
            (Size == 2'b10 && Addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    case (state_q)
      IDLE: if (Req) begin
        addr_d  = Addr;
        size_d  = Size;
        we_d    = ReqWE;
        uns_d   = Unsigned;
        sdata_d = StoreData[15:0];
        if (misal)                            state_d = ERR;
        else if (!ReqWE)                      state_d = RD;
        else if (Size == 2'b10) begin
          // Whole-word store skips the read and writes StoreData directly.
          wdata_d = StoreData;
          state_d = WR;
        end
        else                                  state_d = RD;
      end
      RD: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          ldata_d = ext;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      sdata_q <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
    end
  end

  // Write enable decodes the state register only, so reset kills it at once.
  assign MemWE      = (state_q == WR);
  assign Ready      = (state_q == IDLE);
  assign Done       = (state_q == RESP) || (state_q == ERR);
  assign Misaligned = (state_q == ERR);
  assign LoadData   = ldata_q;
  assign MemAddr    = addr_q[BITS_ADDR-1:2];
  assign MemWData   = wdata_q;

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit that sits between the core's execute stage and the word-organised data memory. The memory has only a whole-word write enable. This block issues the memory accesses for byte, halfword and word loads and stores. Sub-word stores are done as a read-modify-write sequence, and loads are extracted with sign or zero extension. It is the initiator side of the data-memory interface: it drives the word address, write data and write enable, and consumes the combinational read data.

## Interface
- BITS_ADDR, 8, byte-address width. The memory holds 2**BITS_ADDR bytes as (2**BITS_ADDR)/4 words.

- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Req  in  1  access request; sampled only when Ready=1.
- ReqWE  in  1  1 = store, 0 = load.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored for stores and word loads.
- Addr  in  BITS_ADDR  byte address.
- StoreData  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- Ready  out  1  block idle and able to accept a request.
- Done  out  1  one-cycle completion pulse.
- Misaligned  out  1  error flag, valid only while Done=1.
- LoadData  out  32  extended load result. Updated on load completion and held otherwise.
- MemAddr  out  BITS_ADDR-2  word address, equal to Addr[BITS_ADDR-1:2].
- MemWData  out  32  word write data.
- MemWE  out  1  word write enable; the memory writes on the rising edge when this is 1.
- MemRData  in  32  combinational read data for MemAddr.

## Operation
- The FSM has five states: IDLE, RD, WR, RESP, ERR. Ready=1 only in IDLE.
- IDLE, when Req=1: latch Addr, Size, ReqWE, Unsigned and StoreData, then check alignment.
  - Size=01 with Addr[0]=1 is misaligned.
  - Size=10 with Addr[1:0]≠0 is misaligned.
  - Size=11 is always an error.
- Next state from IDLE:
  - error → ERR.
  - load → RD.
  - word store → WR.
  - byte or halfword store → RD.
- Lane mapping is little-endian within the word:
  - byte lane k = Addr[1:0] occupies bits [8k+7:8k].
  - halfword lane h = Addr[1] occupies bits [16h+15:16h].
- RD:
  - MemAddr is driven from the latched address and MemRData is sampled at the end of the cycle.
  - For a load: extract the lane, extend it, register it into LoadData, then go to RESP.
  - For a sub-word store: register the merged word (the read word with the target lane replaced by StoreData[7:0] or [15:0]) into MemWData, then go to WR.
- WR: MemWE=1 for exactly this one cycle. MemWData is the merged word, or StoreData for a word store. Next state is RESP.
- RESP: Done=1, Misaligned=0, then return to IDLE.
- ERR: Done=1, Misaligned=1, then return to IDLE. No memory write occurs and LoadData is unchanged.
- MemWE is 1 only in WR; it is a decode of the registered state.
- Req while Ready=0 is ignored and not queued.

## Timing
- Reset (RST_N=0), takes effect immediately:
  - state = IDLE; Ready=1; Done=0; Misaligned=0; MemWE=0.
  - LoadData=0; MemAddr=0; MemWData=0.
- Reset asserted mid-operation, including in WR: MemWE falls asynchronously, so no partial write reaches memory and the access is discarded. No Done is produced.
- Latency, with the request accepted at edge N:
  - load: Done in cycle N+2, with LoadData valid in the same cycle.
  - word store: MemWE in cycle N+1, Done in cycle N+2.
  - sub-word store: read in cycle N+1, MemWE in cycle N+2, Done in cycle N+3.
  - error: Done with Misaligned=1 in cycle N+1.
- Ready returns to 1 in the cycle after Done. Minimum issue interval is 3 cycles for a load or word store, 4 for a sub-word store, 2 for an error.
- MemAddr is stable from the cycle after acceptance through Done.
- The address wraps naturally at 2**BITS_ADDR; there is no bounds checking.

## Test plan
- Reset: hold RST_N=0 mid-run → Ready=1, Done=0, MemWE=0, LoadData=0 immediately; after release, the first Req is accepted.
- Word store then load: store 0xDEADBEEF to Addr 0x10 → MemWE=1 for one cycle with MemAddr=0x04 and MemWData=0xDEADBEEF, Done at N+2. Then a word load of 0x10 → LoadData=0xDEADBEEF at N+2.
- Byte store: with word 4 preloaded to 0x11223344, store byte 0xAA to 0x11 → write of 0x1122AA44 at N+2, Done at N+3. Then:
  - signed byte load of 0x11 → 0xFFFFFFAA.
  - unsigned byte load of 0x11 → 0x000000AA.
- Halfword: store 0x8001 to 0x12 → word becomes 0x8001AA44. Then:
  - signed halfword load of 0x12 → 0xFFFF8001.
  - unsigned halfword load of 0x12 → 0x00008001.
- Errors: halfword store to 0x13, word load from 0x12, and Size=11 → each gives Done=1 and Misaligned=1 at N+1. MemWE never goes to 1, memory is unchanged, and LoadData holds its previous value.
- Reset during WR of a byte store → MemWE drops without a clock edge, the memory word is unchanged, and no Done pulse is produced. Req during the busy cycles is ignored.
